// File: rtl/execute_stage.sv
// Execute stage of the pipeline. It forwards operands, runs the ALU, resolves branches and jumps,
// and holds an iterative RV32M multiply/divide unit. It also owns the EX/MEM register.
module execute_stage #(
  parameter int XLEN    = 32,
  parameter int MD_ITER = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] imm_in,
  input  logic [XLEN-1:0] rd_1_in,
  input  logic [XLEN-1:0] rd_2_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic            reg_write_in,
  input  logic            is_imm_in,
  input  logic            mem_read_in,
  input  logic            mem_write_in,
  input  logic            mem_to_reg_in,
  input  logic            jump_in,
  input  logic            branch_in,
  input  logic            U_type_in,
  input  logic [2:0]      alu_op_in,
  input  logic [2:0]      funct3_in,
  input  logic            funct7b5_in,
  input  logic            funct7b0_in,
  input  logic [4:0]      rd_in,
  input  logic [4:0]      rs1_in,
  input  logic [4:0]      rs2_in,
  input  logic [6:0]      op_in,
  input  logic            fwd_mem_we,
  input  logic            fwd_wb_we,
  input  logic [4:0]      fwd_mem_rd,
  input  logic [4:0]      fwd_wb_rd,
  input  logic [XLEN-1:0] fwd_mem_data,
  input  logic [XLEN-1:0] fwd_wb_data,
  output logic [XLEN-1:0] alu_result_out,
  output logic [XLEN-1:0] store_data_out,
  output logic [4:0]      rd_out,
  output logic [2:0]      funct3_out,
  output logic            reg_write_out,
  output logic            mem_read_out,
  output logic            mem_write_out,
  output logic            mem_to_reg_out,
  output logic            pc_redirect,
  output logic [XLEN-1:0] redirect_target,
  output logic            ex_busy
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam int         CW       = $clog2(MD_ITER + 1);

  typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_t;

  // ---------------------------------------------------------------- forwarding
  logic [XLEN-1:0] fwd_a, fwd_b, op_b;

  function automatic logic [XLEN-1:0] forward(input logic [4:0] rs, input logic [XLEN-1:0] id_val);
    if (fwd_mem_we && fwd_mem_rd == rs && rs != 5'd0)
      return fwd_mem_data;
    else if (fwd_wb_we && fwd_wb_rd == rs && rs != 5'd0)
      return fwd_wb_data;
    else
      return id_val;
  endfunction

  assign fwd_a = forward(rs1_in, rd_1_in);
  assign fwd_b = forward(rs2_in, rd_2_in);
  assign op_b  = is_imm_in ? imm_in : fwd_b;

  // ---------------------------------------------------------------- ALU
  logic [4:0]             shamt;
  logic signed [XLEN-1:0] sra_res;
  logic                   slt_ab, sltu_ab;
  logic [XLEN-1:0]        alu_res, ex_res, pc_plus4, pc_imm;

  assign shamt    = op_b[4:0];
  // Kept in its own signed net so the arithmetic shift is never turned into a logical shift.
  assign sra_res  = $signed(fwd_a) >>> shamt;
  assign slt_ab   = $signed(fwd_a) < $signed(op_b);
  assign sltu_ab  = fwd_a < op_b;
  assign pc_plus4 = pc_in + XLEN'(4);
  assign pc_imm   = pc_in + imm_in;

  // NOTE: combinational blocks use blocking '=' and assign a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    alu_res = fwd_a + op_b;
    case (alu_op_in)
      3'b001: alu_res = fwd_a - op_b;
      3'b010: begin
        case (funct3_in)
          3'b000:  alu_res = (funct7b5_in && op_in == OP_R) ? fwd_a - op_b : fwd_a + op_b;
          3'b001:  alu_res = fwd_a << shamt;
          3'b010:  alu_res = {{(XLEN-1){1'b0}}, slt_ab};
          3'b011:  alu_res = {{(XLEN-1){1'b0}}, sltu_ab};
          3'b100:  alu_res = fwd_a ^ op_b;
          3'b101:  alu_res = funct7b5_in ? sra_res : fwd_a >> shamt;
          3'b110:  alu_res = fwd_a | op_b;
          default: alu_res = fwd_a & op_b;
        endcase
      end
      3'b011:  alu_res = imm_in;
      default: alu_res = fwd_a + op_b;
    endcase
  end

  always_comb begin
    ex_res = alu_res;
    if (jump_in)
      ex_res = pc_plus4;
    else if (U_type_in && op_in == OP_LUI)
      ex_res = imm_in;
    else if (U_type_in && op_in == OP_AUIPC)
      ex_res = pc_imm;
  end

  // ---------------------------------------------------------------- branch / jump
  logic            br_eq, br_lt, br_ltu, br_cond;
  logic [XLEN-1:0] jalr_sum;

  assign br_eq    = fwd_a == fwd_b;
  assign br_lt    = $signed(fwd_a) < $signed(fwd_b);
  assign br_ltu   = fwd_a < fwd_b;
  assign jalr_sum = fwd_a + imm_in;

  always_comb begin
    br_cond = 1'b0;
    case (funct3_in)
      3'b000:  br_cond = br_eq;
      3'b001:  br_cond = !br_eq;
      3'b100:  br_cond = br_lt;
      3'b101:  br_cond = !br_lt;
      3'b110:  br_cond = br_ltu;
      3'b111:  br_cond = !br_ltu;
      default: br_cond = 1'b0;
    endcase
  end

  assign redirect_target = (jump_in && op_in == OP_JALR)
                         ? (jalr_sum & {{(XLEN-1){1'b1}}, 1'b0})
                         : pc_imm;

  // ---------------------------------------------------------------- multiply / divide
  md_state_t       md_state;
  logic [CW-1:0]   md_cnt;
  logic [2:0]      md_f3;
  logic            md_neg_q, md_neg_r, md_divz;
  logic [XLEN-1:0] md_hi, md_lo, md_b;
  logic            is_md, a_signed, b_signed, sa, sb;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN:0]   mul_sum, div_shift;
  logic [XLEN-1:0] div_sub;
  logic            div_ge;
  logic [XLEN-1:0] step_hi, step_lo;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0] md_result;

  assign is_md    = (op_in == OP_R) && funct7b0_in;
  assign a_signed = (funct3_in == 3'b001) || (funct3_in == 3'b010) ||
                    (funct3_in == 3'b100) || (funct3_in == 3'b110);
  assign b_signed = (funct3_in == 3'b001) || (funct3_in == 3'b100) || (funct3_in == 3'b110);
  assign sa       = a_signed && fwd_a[XLEN-1];
  assign sb       = b_signed && fwd_b[XLEN-1];
  assign a_mag    = sa ? -fwd_a : fwd_a;
  assign b_mag    = sb ? -fwd_b : fwd_b;

  // Multiply: {hi,lo} is accumulator:multiplier. Divide: hi is the partial remainder and lo shifts
  // the dividend out while the quotient shifts in.
  assign mul_sum   = {1'b0, md_hi} + (md_lo[0] ? {1'b0, md_b} : '0);
  assign div_shift = {md_hi, md_lo[XLEN-1]};
  assign div_ge    = div_shift >= {1'b0, md_b};
  assign div_sub   = div_shift[XLEN-1:0] - md_b;

  always_comb begin
    step_hi = mul_sum[XLEN:1];
    step_lo = {mul_sum[0], md_lo[XLEN-1:1]};
    if (md_f3[2]) begin
      step_hi = div_ge ? div_sub : div_shift[XLEN-1:0];
      step_lo = {md_lo[XLEN-2:0], div_ge};
    end
  end

  assign prod_fix = md_neg_q ? -{md_hi, md_lo} : {md_hi, md_lo};

  always_comb begin
    md_result = prod_fix[XLEN-1:0];
    case (md_f3)
      3'b000:                 md_result = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: md_result = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         md_result = md_divz ? '1 : (md_neg_q ? -md_lo : md_lo);
      default:                md_result = md_neg_r ? -md_hi : md_hi;
    endcase
  end

  // NOTE: sequential blocks use non-blocking '<=' so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      md_state <= MD_IDLE;
      md_cnt   <= '0;
    end else begin
      case (md_state)
        MD_IDLE: if (is_md) begin
          md_state <= MD_BUSY;
          md_cnt   <= '0;
        end
        MD_BUSY: begin
          md_cnt <= md_cnt + CW'(1);
          if (md_cnt == CW'(MD_ITER - 1))
            md_state <= MD_DONE;
        end
        default: md_state <= MD_IDLE;
      endcase
    end
  end

  // NOTE: the datapath registers carry no reset; the FSM guarantees they are loaded at capture
  // before anything reads them.
  always_ff @(posedge clk) begin
    if (md_state == MD_IDLE) begin
      md_hi    <= '0;
      md_lo    <= a_mag;
      md_b     <= b_mag;
      md_f3    <= funct3_in;
      md_neg_q <= sa ^ sb;
      md_neg_r <= sa;
      md_divz  <= (fwd_b == '0);
    end else if (md_state == MD_BUSY) begin
      md_hi <= step_hi;
      md_lo <= step_lo;
    end
  end

  assign ex_busy     = (md_state == MD_BUSY) || (md_state == MD_IDLE && is_md);
  assign pc_redirect = (jump_in || (branch_in && br_cond)) && !ex_busy;

  // ---------------------------------------------------------------- EX/MEM register
  always_ff @(posedge clk) begin
    if (rst || ex_busy) begin
      alu_result_out <= '0;
      store_data_out <= '0;
      rd_out         <= '0;
      funct3_out     <= '0;
      reg_write_out  <= 1'b0;
      mem_read_out   <= 1'b0;
      mem_write_out  <= 1'b0;
      mem_to_reg_out <= 1'b0;
    end else begin
      alu_result_out <= (md_state == MD_DONE) ? md_result : ex_res;
      store_data_out <= fwd_b;
      rd_out         <= rd_in;
      funct3_out     <= funct3_in;
      reg_write_out  <= reg_write_in;
      mem_read_out   <= mem_read_in;
      mem_write_out  <= mem_write_in;
      mem_to_reg_out <= mem_to_reg_in;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage. Expected EX/MEM results are queued when an instruction
// is driven and are compared when the DUT registers its output.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imm_in, rd_1_in, rd_2_in, pc_in;
  logic        reg_write_in, is_imm_in, mem_read_in, mem_write_in, mem_to_reg_in;
  logic        jump_in, branch_in, U_type_in;
  logic [2:0]  alu_op_in, funct3_in;
  logic        funct7b5_in, funct7b0_in;
  logic [4:0]  rd_in, rs1_in, rs2_in;
  logic [6:0]  op_in;
  logic        fwd_mem_we, fwd_wb_we;
  logic [4:0]  fwd_mem_rd, fwd_wb_rd;
  logic [31:0] fwd_mem_data, fwd_wb_data;
  logic [31:0] alu_result_out, store_data_out, redirect_target;
  logic [4:0]  rd_out;
  logic [2:0]  funct3_out;
  logic        reg_write_out, mem_read_out, mem_write_out, mem_to_reg_out;
  logic        pc_redirect, ex_busy;

  always #5 clk = ~clk;

  execute_stage dut (
    .clk(clk), .rst(rst),
    .imm_in(imm_in), .rd_1_in(rd_1_in), .rd_2_in(rd_2_in), .pc_in(pc_in),
    .reg_write_in(reg_write_in), .is_imm_in(is_imm_in), .mem_read_in(mem_read_in),
    .mem_write_in(mem_write_in), .mem_to_reg_in(mem_to_reg_in), .jump_in(jump_in),
    .branch_in(branch_in), .U_type_in(U_type_in), .alu_op_in(alu_op_in),
    .funct3_in(funct3_in), .funct7b5_in(funct7b5_in), .funct7b0_in(funct7b0_in),
    .rd_in(rd_in), .rs1_in(rs1_in), .rs2_in(rs2_in), .op_in(op_in),
    .fwd_mem_we(fwd_mem_we), .fwd_wb_we(fwd_wb_we), .fwd_mem_rd(fwd_mem_rd),
    .fwd_wb_rd(fwd_wb_rd), .fwd_mem_data(fwd_mem_data), .fwd_wb_data(fwd_wb_data),
    .alu_result_out(alu_result_out), .store_data_out(store_data_out), .rd_out(rd_out),
    .funct3_out(funct3_out), .reg_write_out(reg_write_out), .mem_read_out(mem_read_out),
    .mem_write_out(mem_write_out), .mem_to_reg_out(mem_to_reg_out),
    .pc_redirect(pc_redirect), .redirect_target(redirect_target), .ex_busy(ex_busy)
  );

  typedef struct {
    logic [31:0] result;
    logic [31:0] store;
    logic [4:0]  rd;
    logic        rw;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic clear_inputs();
    imm_in = '0; rd_1_in = '0; rd_2_in = '0; pc_in = '0;
    reg_write_in = 0; is_imm_in = 0; mem_read_in = 0; mem_write_in = 0; mem_to_reg_in = 0;
    jump_in = 0; branch_in = 0; U_type_in = 0;
    alu_op_in = '0; funct3_in = '0; funct7b5_in = 0; funct7b0_in = 0;
    rd_in = '0; rs1_in = '0; rs2_in = '0; op_in = '0;
    fwd_mem_we = 0; fwd_wb_we = 0; fwd_mem_rd = '0; fwd_wb_rd = '0;
    fwd_mem_data = '0; fwd_wb_data = '0;
  endtask

  task automatic drive_r(input logic [2:0] f3, input logic f7b5, input logic f7b0,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] v1, input logic [31:0] v2);
    clear_inputs();
    op_in = 7'b0110011; alu_op_in = 3'b010; reg_write_in = 1;
    funct3_in = f3; funct7b5_in = f7b5; funct7b0_in = f7b0;
    rd_in = rd; rs1_in = rs1; rs2_in = rs2; rd_1_in = v1; rd_2_in = v2;
  endtask

  task automatic push_exp(input logic [31:0] result, input logic [31:0] store,
                          input logic [4:0] rd, input logic rw);
    exp_t e;
    e.result = result; e.store = store; e.rd = rd; e.rw = rw;
    sb_q.push_back(e);
  endtask

  // ------------------------------------------------------------------ reset
  task automatic test_reset();
    rst = 1;
    drive_r(3'b000, 0, 0, 5'd3, 5'd1, 5'd2, 32'd11, 32'd22);
    mem_read_in = 1; mem_write_in = 1; mem_to_reg_in = 1;
    @(posedge clk); #1;
    n_checks++;
    if ({alu_result_out, store_data_out} !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_data: got result=%h store=%h, expected 0 and 0", alu_result_out, store_data_out);
    end
    n_checks++;
    if ({rd_out, funct3_out, reg_write_out, mem_read_out, mem_write_out, mem_to_reg_out} !== 12'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got rd=%0d f3=%0d rw=%b mr=%b mw=%b m2r=%b, expected all 0",
               rd_out, funct3_out, reg_write_out, mem_read_out, mem_write_out, mem_to_reg_out);
    end
    rst = 0;
    clear_inputs();
  endtask

  // ------------------------------------------------------------------ forwarding
  task automatic test_forwarding();
    logic [4:0]  rs1_t [5];
    logic [4:0]  rs2_t [5];
    logic [4:0]  mrd_t [5];
    logic [4:0]  wrd_t [5];
    logic        mwe_t [5];
    logic [31:0] v1_t  [5];
    logic [31:0] res_t [5];
    logic [31:0] st_t  [5];
    exp_t e;
    rs1_t = '{5'd2, 5'd1, 5'd0, 5'd2, 5'd1};
    rs2_t = '{5'd3, 5'd3, 5'd3, 5'd1, 5'd3};
    mrd_t = '{5'd1, 5'd1, 5'd0, 5'd4, 5'd1};
    wrd_t = '{5'd1, 5'd1, 5'd0, 5'd1, 5'd1};
    mwe_t = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    v1_t  = '{32'd5, 32'd5, 32'd0, 32'd5, 32'd5};
    res_t = '{32'd12, 32'd107, 32'd7, 32'd205, 32'd207};
    st_t  = '{32'd7, 32'd7, 32'd7, 32'd200, 32'd7};
    for (int i = 0; i < 5; i++) begin
      drive_r(3'b000, 0, 0, 5'd3, rs1_t[i], rs2_t[i], v1_t[i], 32'd7);
      fwd_mem_we = mwe_t[i]; fwd_mem_rd = mrd_t[i]; fwd_mem_data = 32'd100;
      fwd_wb_we = 1;         fwd_wb_rd = wrd_t[i];  fwd_wb_data = 32'd200;
      push_exp(res_t[i], st_t[i], 5'd3, 1'b1);
      @(posedge clk); #1;
      e = sb_q.pop_front();
      n_checks++;
      if (alu_result_out !== e.result || store_data_out !== e.store ||
          rd_out !== e.rd || reg_write_out !== e.rw) begin
        n_fail++;
        $display("FAIL forward_case%0d: got result=%0d store=%0d rd=%0d rw=%b, expected %0d %0d %0d %b",
                 i, alu_result_out, store_data_out, rd_out, reg_write_out, e.result, e.store, e.rd, e.rw);
      end
    end
    clear_inputs();
  endtask

  // ------------------------------------------------------------------ ALU ops
  task automatic test_alu();
    logic [2:0]  f3_t [10];
    logic        f7_t [10];
    logic [31:0] ex_t [10];
    exp_t e;
    f3_t = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd7};
    f7_t = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    ex_t = '{32'h800000F4, 32'h800000EC, 32'h00000F00, 32'h00000001, 32'h00000000,
             32'h800000F4, 32'h0800000F, 32'hF800000F, 32'h800000F4, 32'h00000000};
    for (int i = 0; i < 14; i++) begin
      if (i < 10) begin
        drive_r(f3_t[i], f7_t[i], 0, 5'd8, 5'd6, 5'd7, 32'h800000F0, 32'd4);
        push_exp(ex_t[i], 32'd4, 5'd8, 1'b1);
      end else if (i == 10) begin
        drive_r(3'b000, 1, 0, 5'd8, 5'd6, 5'd0, 32'd10, 32'd0);
        op_in = 7'b0010011; is_imm_in = 1; imm_in = 32'd3;
        push_exp(32'd13, 32'd0, 5'd8, 1'b1);
      end else if (i == 11) begin
        clear_inputs();
        U_type_in = 1; op_in = 7'b0110111; imm_in = 32'h12345000; rd_1_in = 32'h55;
        reg_write_in = 1; rd_in = 5'd9;
        push_exp(32'h12345000, 32'd0, 5'd9, 1'b1);
      end else if (i == 12) begin
        clear_inputs();
        U_type_in = 1; op_in = 7'b0010111; imm_in = 32'h12345000; pc_in = 32'h1000;
        rd_1_in = 32'h55; reg_write_in = 1; rd_in = 5'd9;
        push_exp(32'h12346000, 32'd0, 5'd9, 1'b1);
      end else begin
        clear_inputs();
        alu_op_in = 3'b011; imm_in = 32'hABCD; rd_1_in = 32'd5; reg_write_in = 1; rd_in = 5'd4;
        push_exp(32'hABCD, 32'd0, 5'd4, 1'b1);
      end
      @(posedge clk); #1;
      e = sb_q.pop_front();
      n_checks++;
      if (alu_result_out !== e.result || rd_out !== e.rd || reg_write_out !== e.rw) begin
        n_fail++;
        $display("FAIL alu_case%0d: got result=%h rd=%0d rw=%b, expected %h %0d %b",
                 i, alu_result_out, rd_out, reg_write_out, e.result, e.rd, e.rw);
      end
    end
    clear_inputs();
  endtask

  // ------------------------------------------------------------------ branches
  task automatic test_branch();
    logic [2:0]  f3_t [7];
    logic [31:0] a_t  [7];
    logic [31:0] b_t  [7];
    logic        tk_t [7];
    f3_t = '{3'b000, 3'b110, 3'b101, 3'b001, 3'b100, 3'b111, 3'b010};
    a_t  = '{32'd5, 32'd1, 32'hFFFFFFFF, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5};
    b_t  = '{32'd5, 32'hFFFFFFFF, 32'd1, 32'd5, 32'd1, 32'd1, 32'd5};
    tk_t = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 7; i++) begin
      clear_inputs();
      op_in = 7'b1100011; branch_in = 1; alu_op_in = 3'b001; funct3_in = f3_t[i];
      rs1_in = 5'd1; rs2_in = 5'd2; rd_1_in = a_t[i]; rd_2_in = b_t[i];
      pc_in = 32'h40; imm_in = 32'h10;
      #3;
      n_checks++;
      if (pc_redirect !== tk_t[i] || redirect_target !== 32'h50) begin
        n_fail++;
        $display("FAIL branch_case%0d: got redirect=%b target=%h, expected %b 00000050",
                 i, pc_redirect, redirect_target, tk_t[i]);
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (reg_write_out !== 1'b0) begin
      n_fail++;
      $display("FAIL branch_no_write: got reg_write_out=%b, expected 0", reg_write_out);
    end
    clear_inputs();
  endtask

  // ------------------------------------------------------------------ jumps
  task automatic test_jump();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      clear_inputs();
      jump_in = 1; reg_write_in = 1; rd_in = 5'd1; is_imm_in = 1;
      if (i == 0) begin
        op_in = 7'b1100111; pc_in = 32'h100; rs1_in = 5'd5; rd_1_in = 32'h203; imm_in = 32'd4;
        push_exp(32'h104, 32'h206, 5'd1, 1'b1);
      end else if (i == 1) begin
        op_in = 7'b1101111; pc_in = 32'h200; imm_in = 32'hFFFFFFF8;
        push_exp(32'h204, 32'h1F8, 5'd1, 1'b1);
      end else begin
        op_in = 7'b1100111; pc_in = 32'h300; rs1_in = 5'd5; rd_1_in = 32'h999; imm_in = 32'd4;
        fwd_mem_we = 1; fwd_mem_rd = 5'd5; fwd_mem_data = 32'h301;
        push_exp(32'h304, 32'h304, 5'd1, 1'b1);
      end
      e = sb_q[$];
      #3;
      n_checks++;
      if (pc_redirect !== 1'b1 || redirect_target !== e.store) begin
        n_fail++;
        $display("FAIL jump_target%0d: got redirect=%b target=%h, expected 1 %h",
                 i, pc_redirect, redirect_target, e.store);
      end
      @(posedge clk); #1;
      e = sb_q.pop_front();
      n_checks++;
      if (alu_result_out !== e.result || reg_write_out !== e.rw || rd_out !== e.rd) begin
        n_fail++;
        $display("FAIL jump_link%0d: got result=%h rw=%b rd=%0d, expected %h %b %0d",
                 i, alu_result_out, reg_write_out, rd_out, e.result, e.rw, e.rd);
      end
    end
    clear_inputs();
  endtask

  // ------------------------------------------------------------------ one M op, start to finish
  task automatic md_op_scenario(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] expv, output int edges);
    int   busy, bad_bubble;
    exp_t e;
    drive_r(f3, 0, 1, 5'd10, 5'd11, 5'd12, a, b);
    push_exp(expv, b, 5'd10, 1'b1);
    busy = 0; bad_bubble = 0; edges = 0;
    for (int c = 0; c < 100; c++) begin
      #3;
      if (!ex_busy) break;
      busy++;
      @(posedge clk); #1;
      edges++;
      if ({reg_write_out, mem_read_out, mem_write_out, mem_to_reg_out} !== 4'd0 ||
          alu_result_out !== 32'd0 || rd_out !== 5'd0)
        bad_bubble++;
    end
    n_checks++;
    if (busy !== 33) begin
      n_fail++;
      $display("FAIL md_busy_len f3=%0d: got %0d busy cycles, expected 33", f3, busy);
    end
    n_checks++;
    if (bad_bubble !== 0) begin
      n_fail++;
      $display("FAIL md_bubble f3=%0d: got %0d non-bubble EX/MEM cycles, expected 0", f3, bad_bubble);
    end
    @(posedge clk); #1;
    edges++;
    e = sb_q.pop_front();
    n_checks++;
    if (alu_result_out !== e.result || reg_write_out !== e.rw || rd_out !== e.rd) begin
      n_fail++;
      $display("FAIL md_result f3=%0d a=%h b=%h: got %h rw=%b rd=%0d, expected %h %b %0d",
               f3, a, b, alu_result_out, reg_write_out, rd_out, e.result, e.rw, e.rd);
    end
  endtask

  task automatic test_muldiv();
    logic [2:0]  f3_t [17];
    logic [31:0] a_t  [17];
    logic [31:0] b_t  [17];
    logic [31:0] r_t  [17];
    int edges;
    f3_t = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd2, 3'd1, 3'd3,
             3'd4, 3'd6, 3'd6, 3'd5, 3'd4, 3'd4, 3'd6, 3'd5, 3'd7, 3'd6};
    a_t  = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF,
             32'h80000000, 32'h80000000, 32'd7, 32'd7, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFF9,
             32'd100, 32'd100, 32'd7};
    b_t  = '{32'd5, 32'd2, 32'd2, 32'hFFFFFFFF, 32'd2, 32'h80000000, 32'hFFFFFFFF,
             32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd0, 32'd2, 32'd2,
             32'd7, 32'd7, 32'hFFFFFFFE};
    r_t  = '{32'hFFFFFFF1, 32'hFFFFFFFF, 32'd1, 32'd1, 32'hFFFFFFFF, 32'h40000000, 32'hFFFFFFFE,
             32'h80000000, 32'd0, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF,
             32'd14, 32'd2, 32'd1};
    for (int i = 0; i < 17; i++)
      md_op_scenario(f3_t[i], a_t[i], b_t[i], r_t[i], edges);
    clear_inputs();
    @(posedge clk); #1;
  endtask

  // ------------------------------------------------------------------ M op straight after M op
  task automatic test_back_to_back();
    int e1, e2;
    md_op_scenario(3'd0, 32'd1000, 32'd3, 32'd3000, e1);
    md_op_scenario(3'd5, 32'd3000, 32'd7, 32'd428, e2);
    n_checks++;
    if (e1 + e2 !== 68) begin
      n_fail++;
      $display("FAIL back_to_back_edges: got %0d edges for two ops, expected 68", e1 + e2);
    end
    clear_inputs();
    @(posedge clk); #1;
  endtask

  // ------------------------------------------------------------------ reset during an M op
  task automatic test_reset_mid_md();
    int edges;
    drive_r(3'd0, 0, 1, 5'd10, 5'd11, 5'd12, 32'h1234, 32'h10);
    repeat (11) @(posedge clk);
    #1;
    n_checks++;
    if (ex_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL md_busy_before_rst: got ex_busy=%b, expected 1", ex_busy);
    end
    rst = 1;
    drive_r(3'd0, 0, 0, 5'd3, 5'd1, 5'd2, 32'd4, 32'd5);
    @(posedge clk); #1;
    n_checks++;
    if ({alu_result_out, reg_write_out, rd_out} !== 38'd0) begin
      n_fail++;
      $display("FAIL rst_mid_md_outputs: got result=%h rw=%b rd=%0d, expected 0 0 0",
               alu_result_out, reg_write_out, rd_out);
    end
    rst = 0;
    clear_inputs();
    #1;
    n_checks++;
    if (ex_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_md_busy: got ex_busy=%b, expected 0", ex_busy);
    end
    @(posedge clk); #1;
    md_op_scenario(3'd0, 32'd6, 32'd7, 32'd42, edges);
    clear_inputs();
    @(posedge clk); #1;
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    @(posedge clk); #1;
    test_reset();
    test_forwarding();
    test_alu();
    test_branch();
    test_jump();
    test_muldiv();
    test_back_to_back();
    test_reset_mid_md();
    n_checks++;
    if (sb_q.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
